// File: rtl/ifm_read_addr_controller_pkg.sv
// Shared definitions for the IFM read / OFM write address controllers:
// FSM encodings, kernel selector constants and the RAM address-width helper.
package ifm_read_addr_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ     = 2'd1,
    ST_TILE_END = 2'd2
  } ctrl_state_t;

  localparam logic KERNEL_1x1 = 1'b0;
  localparam logic KERNEL_3x3 = 1'b1;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ifm_read_addr_controller_tile_geometry.sv
// Column-block geometry of the current tile: width W = min(SYSTOLIC_SIZE, OW - c)
// and the segment length W + K - 1, registered so they are stable for the whole tile.
module ifm_tile_geometry
  import ifm_read_addr_controller_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  localparam int SZW = $clog2(SYSTOLIC_SIZE + 3)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [8:0]     col,
  input  logic [8:0]     ow,
  input  logic           kernel_3x3,
  output logic [8:0]     tile_w,
  output logic [SZW-1:0] read_ifm_size
);

  logic [8:0]     remain;
  logic [8:0]     w_next;
  logic [SZW-1:0] size_next;

  always_comb begin
    remain    = ow - col;
    w_next    = (remain > 9'(SYSTOLIC_SIZE)) ? 9'(SYSTOLIC_SIZE) : remain;
    size_next = SZW'(w_next) + ((kernel_3x3 == KERNEL_3x3) ? SZW'(2) : SZW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_w        <= '0;
      read_ifm_size <= '0;
    end else begin
      tile_w        <= w_next;
      read_ifm_size <= size_next;
    end
  end

endmodule

// File: rtl/ifm_read_addr_controller.sv
// IFM read address generator: walks output tiles in raster order and issues one
// wide-row read per (channel, kernel row); all offsets are built by accumulation.
module ifm_read_addr_controller
  import ifm_read_addr_controller_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int IFM_RAM_SIZE  = 2378675,
  localparam int AW  = addr_width(IFM_RAM_SIZE),
  localparam int SZW = $clog2(SYSTOLIC_SIZE + 3)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  start_read_addr,
  input  logic [8:0]     ifm_size,
  input  logic [10:0]    num_channel,
  input  logic           kernel_3x3,
  input  logic           next_tile,
  input  logic           hold,
  output logic [AW-1:0]  ifm_addr,
  output logic           ifm_rd_en,
  output logic [SZW-1:0] read_ifm_size,
  output logic           tile_done,
  output logic           layer_done,
  output logic           busy,
  output ctrl_state_t    fsm_state
);

  ctrl_state_t state, next_state;

  logic [AW-1:0] start_addr_q;
  logic [8:0]    size_q;
  logic [10:0]   nc_q;
  logic          k3_q;
  logic [8:0]    ow_q;
  logic [17:0]   plane_q;

  logic [8:0]    h_q;
  logic [8:0]    c_q;
  logic [10:0]   ch_q;
  logic [1:0]    ky_q;
  logic [AW-1:0] row_base_q;
  logic [AW-1:0] tile_base_q;
  logic [AW-1:0] ch_base_q;

  logic [8:0]    tile_w;
  logic          last_ky;
  logic          last_ch;
  logic          last_issue;
  logic          last_col;
  logic          last_row;
  logic [AW-1:0] size_ext;
  logic [AW-1:0] plane_ext;

  ifm_tile_geometry #(.SYSTOLIC_SIZE(SYSTOLIC_SIZE)) u_geometry (
    .clk           (clk),
    .rst_n         (rst_n),
    .col           (c_q),
    .ow            (ow_q),
    .kernel_3x3    (k3_q),
    .tile_w        (tile_w),
    .read_ifm_size (read_ifm_size)
  );

  always_comb begin
    last_ky    = (ky_q == ((k3_q == KERNEL_3x3) ? 2'd2 : 2'd0));
    last_ch    = (ch_q == nc_q - 11'd1);
    last_issue = last_ky && last_ch;
    last_col   = ({1'b0, c_q} + {1'b0, tile_w}) >= {1'b0, ow_q};
    last_row   = (h_q == ow_q - 9'd1);
    size_ext   = AW'(size_q);
    plane_ext  = AW'(plane_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // start overrides everything; next_tile is only honoured from IDLE.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (next_tile) next_state = ST_READ;
        ST_READ:     if (!hold && last_issue) next_state = ST_TILE_END;
        ST_TILE_END: next_state = ST_IDLE;
        default:     next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == ST_READ);
    tile_done  = (state == ST_TILE_END);
    layer_done = (state == ST_TILE_END) && last_col && last_row;
    fsm_state  = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_addr_q <= '0;
      size_q       <= '0;
      nc_q         <= '0;
      k3_q         <= 1'b0;
      ow_q         <= '0;
      plane_q      <= '0;
      h_q          <= '0;
      c_q          <= '0;
      ch_q         <= '0;
      ky_q         <= '0;
      row_base_q   <= '0;
      tile_base_q  <= '0;
      ch_base_q    <= '0;
      ifm_addr     <= '0;
      ifm_rd_en    <= 1'b0;
    end else if (start) begin
      start_addr_q <= start_read_addr;
      size_q       <= ifm_size;
      nc_q         <= num_channel;
      k3_q         <= kernel_3x3;
      ow_q         <= ifm_size - ((kernel_3x3 == KERNEL_3x3) ? 9'd2 : 9'd0);
      plane_q      <= {9'd0, ifm_size} * {9'd0, ifm_size};
      h_q          <= '0;
      c_q          <= '0;
      ch_q         <= '0;
      ky_q         <= '0;
      row_base_q   <= start_read_addr;
      tile_base_q  <= start_read_addr;
      ch_base_q    <= start_read_addr;
      ifm_rd_en    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (next_tile) begin
            ch_q      <= '0;
            ky_q      <= '0;
            ch_base_q <= tile_base_q;
            ifm_addr  <= tile_base_q;
            ifm_rd_en <= 1'b1;
          end
        end
        // ifm_addr always holds the address of (ch_q, ky_q); hold just withholds the next step.
        ST_READ: begin
          if (hold || last_issue) begin
            ifm_rd_en <= 1'b0;
          end else if (last_ky) begin
            ch_q      <= ch_q + 11'd1;
            ky_q      <= '0;
            ch_base_q <= ch_base_q + plane_ext;
            ifm_addr  <= ch_base_q + plane_ext;
            ifm_rd_en <= 1'b1;
          end else begin
            ky_q      <= ky_q + 2'd1;
            ifm_addr  <= ifm_addr + size_ext;
            ifm_rd_en <= 1'b1;
          end
        end
        ST_TILE_END: begin
          ifm_rd_en <= 1'b0;
          ch_q      <= '0;
          ky_q      <= '0;
          if (last_col) begin
            c_q <= '0;
            if (last_row) begin
              h_q         <= '0;
              row_base_q  <= start_addr_q;
              tile_base_q <= start_addr_q;
            end else begin
              h_q         <= h_q + 9'd1;
              row_base_q  <= row_base_q + size_ext;
              tile_base_q <= row_base_q + size_ext;
            end
          end else begin
            c_q         <= c_q + tile_w;
            tile_base_q <= tile_base_q + AW'(tile_w);
          end
        end
        default: ifm_rd_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_read_addr_controller.sv
// Directed bench for ifm_read_addr_controller: two instances (array width 4 and 16)
// share stimulus; a vector table covers whole tiles, hand sequences cover hold/abort/reset.
module tb_ifm_read_addr_controller;
  import ifm_read_addr_controller_pkg::*;

  localparam int AW = addr_width(2378675);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_read_addr;
  logic [8:0]    ifm_size;
  logic [10:0]   num_channel;
  logic          kernel_3x3;
  logic          next_tile;
  logic          hold;

  logic [AW-1:0] addr4, addr16;
  logic          en4, en16;
  logic [2:0]    rsz4;
  logic [4:0]    rsz16;
  logic          td4, td16, ld4, ld16, busy4, busy16;
  ctrl_state_t   st4, st16;

  logic          sel16;
  logic [AW-1:0] o_addr;
  logic          o_rd_en, o_tile_done, o_layer_done, o_busy;
  logic [4:0]    o_rsz;
  ctrl_state_t   o_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit use16;
    bit do_start;
    int size;
    bit k3;
    int nc;
    int base;
    int n_addr;
    int addr[6];
    int rsz;
    bit ldone;
  } vec_t;

  vec_t vecs[$];

  ifm_read_addr_controller #(.SYSTOLIC_SIZE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_read_addr(start_read_addr),
    .ifm_size(ifm_size), .num_channel(num_channel), .kernel_3x3(kernel_3x3),
    .next_tile(next_tile), .hold(hold), .ifm_addr(addr4), .ifm_rd_en(en4),
    .read_ifm_size(rsz4), .tile_done(td4), .layer_done(ld4), .busy(busy4),
    .fsm_state(st4)
  );

  ifm_read_addr_controller #(.SYSTOLIC_SIZE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .start_read_addr(start_read_addr),
    .ifm_size(ifm_size), .num_channel(num_channel), .kernel_3x3(kernel_3x3),
    .next_tile(next_tile), .hold(hold), .ifm_addr(addr16), .ifm_rd_en(en16),
    .read_ifm_size(rsz16), .tile_done(td16), .layer_done(ld16), .busy(busy16),
    .fsm_state(st16)
  );

  always_comb begin
    o_addr       = sel16 ? addr16 : addr4;
    o_rd_en      = sel16 ? en16 : en4;
    o_rsz        = sel16 ? rsz16 : {2'b00, rsz4};
    o_tile_done  = sel16 ? td16 : td4;
    o_layer_done = sel16 ? ld16 : ld4;
    o_busy       = sel16 ? busy16 : busy4;
    o_state      = sel16 ? st16 : st4;
  end

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit use16, input bit do_start, input int size, input bit k3,
                         input int nc, input int base, input int n_addr,
                         input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int rsz, input bit ldone);
    vec_t v;
    v.use16 = use16; v.do_start = do_start; v.size = size; v.k3 = k3;
    v.nc = nc; v.base = base; v.n_addr = n_addr;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.addr[3] = a3; v.addr[4] = a4; v.addr[5] = a5;
    v.rsz = rsz; v.ldone = ldone;
    vecs.push_back(v);
  endtask

  // driver tasks
  task automatic apply_start(input int size, input bit k3, input int nc, input int base);
    @(posedge clk); #1;
    ifm_size        = 9'(size);
    kernel_3x3      = k3;
    num_channel     = 11'(nc);
    start_read_addr = AW'(base);
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_next_tile();
    @(posedge clk); #1 next_tile = 1'b1;
    @(posedge clk); #1 next_tile = 1'b0;
  endtask

  task automatic expect_addr(input string tag, input int exp);
    @(negedge clk);
    check({tag, " rd_en"}, int'(o_rd_en), 1);
    check({tag, " addr"}, int'(o_addr), exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    sel16 = v.use16;
    if (v.do_start) apply_start(v.size, v.k3, v.nc, v.base);
    pulse_next_tile();
    for (int i = 0; i < v.n_addr; i++) begin
      expect_addr($sformatf("v%0d a%0d", idx, i), v.addr[i]);
      if (i == 0) begin
        check($sformatf("v%0d read_ifm_size", idx), int'(o_rsz), v.rsz);
        check($sformatf("v%0d busy", idx), int'(o_busy), 1);
      end
    end
    @(negedge clk);
    check($sformatf("v%0d end rd_en", idx), int'(o_rd_en), 0);
    check($sformatf("v%0d tile_done", idx), int'(o_tile_done), 1);
    check($sformatf("v%0d layer_done", idx), int'(o_layer_done), int'(v.ldone));
    @(negedge clk);
    check($sformatf("v%0d tile_done pulse", idx), int'(o_tile_done), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_read_addr = '0; ifm_size = '0;
    num_channel = '0; kernel_3x3 = 1'b0; next_tile = 1'b0; hold = 1'b0; sel16 = 1'b0;

    // 6x6 3x3, 2 channels, base 100, array width 4
    add_vec(1'b0, 1'b1, 6, 1'b1, 2, 100, 6, 100, 106, 112, 136, 142, 148, 6, 1'b0);
    // 8x8 3x3, 1 channel: full block, partial block (W=2), then next tile row
    add_vec(1'b0, 1'b1, 8, 1'b1, 1, 0, 3, 0, 8, 16, 0, 0, 0, 6, 1'b0);
    add_vec(1'b0, 1'b0, 8, 1'b1, 1, 0, 3, 4, 12, 20, 0, 0, 0, 4, 1'b0);
    add_vec(1'b0, 1'b0, 8, 1'b1, 1, 0, 3, 8, 16, 24, 0, 0, 0, 6, 1'b0);
    // 5x5 1x1, 3 channels, array width 16: five tiles, layer_done on the last, then wrap
    add_vec(1'b1, 1'b1, 5, 1'b0, 3, 0, 3, 0, 25, 50, 0, 0, 0, 5, 1'b0);
    add_vec(1'b1, 1'b0, 5, 1'b0, 3, 0, 3, 5, 30, 55, 0, 0, 0, 5, 1'b0);
    add_vec(1'b1, 1'b0, 5, 1'b0, 3, 0, 3, 10, 35, 60, 0, 0, 0, 5, 1'b0);
    add_vec(1'b1, 1'b0, 5, 1'b0, 3, 0, 3, 15, 40, 65, 0, 0, 0, 5, 1'b0);
    add_vec(1'b1, 1'b0, 5, 1'b0, 3, 0, 3, 20, 45, 70, 0, 0, 0, 5, 1'b1);
    add_vec(1'b1, 1'b0, 5, 1'b0, 3, 0, 3, 0, 25, 50, 0, 0, 0, 5, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rd_en", int'(o_rd_en), 0);
    check("reset addr", int'(o_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset busy", int'(o_busy), 0);
    check("post-reset tile_done", int'(o_tile_done), 0);
    check("post-reset layer_done", int'(o_layer_done), 0);
    check("post-reset read_ifm_size", int'(o_rsz), 0);
    check("post-reset state", int'(o_state), int'(ST_IDLE));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // hold for 3 cycles after the second address; a stray next_tile in READ is ignored
    sel16 = 1'b0;
    apply_start(6, 1'b1, 2, 100);
    pulse_next_tile();
    expect_addr("hold a0", 100);
    @(posedge clk); #1 hold = 1'b1; next_tile = 1'b1;
    expect_addr("hold a1", 106);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold stall%0d rd_en", k), int'(o_rd_en), 0);
      check($sformatf("hold stall%0d addr", k), int'(o_addr), 106);
      check($sformatf("hold stall%0d busy", k), int'(o_busy), 1);
      if (k == 0) next_tile = 1'b0;
      if (k == 2) hold = 1'b0;
    end
    expect_addr("hold a2", 112);
    expect_addr("hold a3", 136);
    expect_addr("hold a4", 142);
    expect_addr("hold a5", 148);
    @(negedge clk);
    check("hold tile_done", int'(o_tile_done), 1);
    @(negedge clk);
    check("hold idle", int'(o_state), int'(ST_IDLE));

    // start mid-READ aborts and loads the new config
    apply_start(6, 1'b1, 2, 100);
    pulse_next_tile();
    expect_addr("abort a0", 100);
    expect_addr("abort a1", 106);
    ifm_size = 9'd8; num_channel = 11'd1; start_read_addr = AW'(1000); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("abort rd_en", int'(o_rd_en), 0);
    check("abort busy", int'(o_busy), 0);
    check("abort state", int'(o_state), int'(ST_IDLE));
    check("abort tile_done", int'(o_tile_done), 0);
    @(negedge clk);
    check("abort no pulse", int'(o_tile_done), 0);
    pulse_next_tile();
    expect_addr("abort new a0", 1000);
    check("abort new read_ifm_size", int'(o_rsz), 6);
    expect_addr("abort new a1", 1008);
    expect_addr("abort new a2", 1016);
    @(negedge clk);
    check("abort new tile_done", int'(o_tile_done), 1);

    // asynchronous reset mid-READ
    apply_start(6, 1'b1, 2, 100);
    pulse_next_tile();
    expect_addr("rst a0", 100);
    expect_addr("rst a1", 106);
    rst_n = 1'b0;
    #1;
    check("rst async rd_en", int'(o_rd_en), 0);
    check("rst async addr", int'(o_addr), 0);
    check("rst async busy", int'(o_busy), 0);
    check("rst async tile_done", int'(o_tile_done), 0);
    check("rst async layer_done", int'(o_layer_done), 0);
    check("rst async read_ifm_size", int'(o_rsz), 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst held%0d tile_done", k), int'(o_tile_done), 0);
      check($sformatf("rst held%0d busy", k), int'(o_busy), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst release rd_en", int'(o_rd_en), 0);
    check("rst release tile_done", int'(o_tile_done), 0);
    run_vec(vecs[0], 100);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifm_read_addr_controller.md
Name: ifm_read_addr_controller

Overview:
Generates read addresses into the IFM RAM that feed input-feature-map row segments to the systolic array. It is the read-side counterpart of the OFM write address controller. The block walks output tiles in raster order: tile row first, then column blocks of up to SYSTOLIC_SIZE outputs. For each tile it issues one wide-row read per (input channel, kernel row). The main layer controller sequences it with a per-tile request and a stall.

Parameters:
SYSTOLIC_SIZE, 16, max output columns per tile (PE array width)
IFM_RAM_SIZE, 2378675, IFM RAM depth in pixels; address width AW = $clog2(IFM_RAM_SIZE)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; latch layer config, clear all counters
start_read_addr  in  AW  base address of channel 0, pixel (0,0)
ifm_size  in  9  IFM width = height (square), 1..416
num_channel  in  11  input channels, >=1
kernel_3x3  in  1  1 = 3x3 kernel, 0 = 1x1; stride 1, no padding
next_tile  in  1  pulse; request address sequence for current tile
hold  in  1  stall; freezes address issue
ifm_addr  out  AW  read address (pixel index of segment start)
ifm_rd_en  out  1  ifm_addr valid this cycle
read_ifm_size  out  $clog2(SYSTOLIC_SIZE+3)  pixels in each segment of current tile
tile_done  out  1  one-cycle pulse after last address of a tile
layer_done  out  1  one-cycle pulse after last tile of layer
busy  out  1  high in READ

Behaviour:
- Derived values, latched on start:
  - K = kernel_3x3 ? 3 : 1
  - OW = ifm_size - K + 1
  - plane = ifm_size*ifm_size, computed with one multiply at start and held in a register.
  - No other multipliers. All channel and row offsets are accumulated by addition.
- Counters:
  - tile_row h in 0..OW-1
  - tile_col c in 0..OW-1
  - ch in 0..num_channel-1
  - ky in 0..K-1
- Tile geometry: W = min(SYSTOLIC_SIZE, OW - c). read_ifm_size = W + K - 1. It is updated whenever c changes and is stable for the whole tile.
- Address rule: ifm_addr = start_read_addr + ch*plane + (h+ky)*ifm_size + c.
  - ky is the inner loop; ch is the outer loop.
  - Each tile issues num_channel*K addresses.
- FSM states: IDLE, READ, TILE_END.
  - IDLE -> READ on next_tile. The first address is valid the cycle after next_tile (latency 1).
  - READ:
    - Issues one address per cycle while hold = 0.
    - While hold = 1, ifm_rd_en = 0 and ifm_addr and all counters are frozen.
    - On the last (ch, ky) with hold = 0, goes to TILE_END.
  - TILE_END (one cycle):
    - tile_done = 1.
    - Advance: c += W. If c reaches OW, then c = 0 and h += 1. If h reaches OW, assert layer_done in the same cycle and clear h and c.
    - Return to IDLE.
- Boundaries:
  - next_tile while in READ or TILE_END is ignored.
  - start has priority in any state: abort, go to IDLE, clear counters, drop ifm_rd_en next cycle, load new config.
  - next_tile after layer_done without a new start restarts from tile (0,0).
  - Last column block is partial when OW is not a multiple of SYSTOLIC_SIZE.
  - Address arithmetic is modulo 2^AW. Configuration must keep addresses below IFM_RAM_SIZE; no checking in hardware.
- Reset values: ifm_addr 0, ifm_rd_en 0, tile_done 0, layer_done 0, busy 0, all counters 0, state IDLE. read_ifm_size resets to 0 and is valid only after start.
- Reset mid-operation returns to IDLE immediately, with no pending pulse.

Decomposition:
- Shared package holds:
  - the FSM state encodings (2-bit: IDLE, READ, TILE_END)
  - an AW function used by both the IFM read and OFM write address controllers
  - a KERNEL_1x1 / KERNEL_3x3 constant pair
- Natural sub-module: ifm_tile_geometry. It is combinational and registered-output: from c, OW and K it yields W and read_ifm_size.
- Address accumulators and FSM stay in the top module.

Test Plan:
- SYSTOLIC_SIZE=4, ifm_size=6, 3x3, num_channel=2, start_read_addr=100, start then next_tile:
  - addresses 100, 106, 112, 136, 142, 148 on consecutive cycles from next_tile+1
  - read_ifm_size=6
  - tile_done one cycle after 148
- SYSTOLIC_SIZE=4, ifm_size=8, 3x3, 1 channel, base 0:
  - tile (0,0) addrs 0, 8, 16, read_ifm_size=6
  - second tile addrs 4, 12, 20, read_ifm_size=4 (W=2)
  - third tile starts at h=1: addrs 8, 16, 24
- ifm_size=5, 1x1, 3 channels, SYSTOLIC_SIZE=16:
  - 5 tiles, each issuing 3 addresses (e.g. row 2: 10, 35, 60)
  - layer_done pulses with the 5th tile_done
  - a next next_tile restarts at address 0
- hold asserted for 3 cycles after the 2nd address of scenario 1:
  - ifm_rd_en low for those 3 cycles, ifm_addr held at 106
  - resumes with 112; total tile length +3 cycles
- start asserted mid-READ (after 2 addresses):
  - ifm_rd_en low next cycle, FSM in IDLE
  - next next_tile begins at start_read_addr of the new config, tile (0,0)
- rst_n low mid-READ:
  - all outputs 0 asynchronously, no tile_done or layer_done pulse
  - after release, behaviour as from power-on
